// File: rtl/ifft_butterfly.sv
// ifft_butterfly: streaming radix-2 inverse butterfly.
// The lower input is rotated back by -zangle with a pipelined CORDIC, gain
// compensated, then summed with / subtracted from the delayed upper input.
// Latency is STAGES+2 cycles.
// Optional macro IFFT_BUTTERFLY_SCALE_EN: outputs scaled by 1/2 (floor),
// otherwise the outputs are the wrapped low 16 bits of the sum/difference.
module ifft_butterfly #(
    parameter int STAGES = 16,
    parameter int IW     = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [15:0] xin1,
    input  logic signed [15:0] yin1,
    input  logic signed [15:0] xin2,
    input  logic signed [15:0] yin2,
    input  logic signed [31:0] zangle,
    output logic               out_valid,
    output logic signed [15:0] xout1,
    output logic signed [15:0] yout1,
    output logic signed [15:0] xout2,
    output logic signed [15:0] yout2
);

    // Fraction guard bits kept below the input LSB; 18 bits cover sign,
    // 16-bit input magnitude, sqrt(2) and the CORDIC gain.
    localparam int unsigned G    = (IW > 18) ? IW - 18 : 0;
    localparam int unsigned PW   = IW + 16;
    localparam int unsigned SW   = 17 + G;
    localparam int          GAIN = 19898;
`ifdef IFFT_BUTTERFLY_SCALE_EN
    localparam int unsigned OSH  = G + 1;
`else
    localparam int unsigned OSH  = G;
`endif

    // arctan(2^-i) in 32-bit binary-angle units
    function automatic logic signed [31:0] atan_lut(input int idx);
        case (idx)
            0:       return 32'sh2000_0000;
            1:       return 32'sh12E4_051E;
            2:       return 32'sh09FB_385B;
            3:       return 32'sh0511_11D4;
            4:       return 32'sh028B_0D43;
            5:       return 32'sh0145_D7E1;
            6:       return 32'sh00A2_F61E;
            7:       return 32'sh0051_7C55;
            8:       return 32'sh0028_BE53;
            9:       return 32'sh0014_5F2F;
            10:      return 32'sh000A_2F98;
            11:      return 32'sh0005_17CC;
            12:      return 32'sh0002_8BE6;
            13:      return 32'sh0001_45F3;
            14:      return 32'sh0000_A2FA;
            15:      return 32'sh0000_517D;
            default: return 32'sh0000_0000;
        endcase
    endfunction

    logic signed [31:0]   w_zn;
    logic signed [31:0]   w_pz;
    logic signed [IW-1:0] w_x2;
    logic signed [IW-1:0] w_y2;
    logic signed [IW-1:0] w_px;
    logic signed [IW-1:0] w_py;

    logic signed [IW-1:0] r_x  [0:STAGES];
    logic signed [IW-1:0] r_y  [0:STAGES];
    logic signed [31:0]   r_z  [0:STAGES-1];
    logic signed [15:0]   r_ax [0:STAGES];
    logic signed [15:0]   r_ay [0:STAGES];
    logic [STAGES:0]      r_v;

    logic signed [SW-1:0] w_rx;
    logic signed [SW-1:0] w_ry;
    logic signed [SW-1:0] w_ax;
    logic signed [SW-1:0] w_ay;

    // Negate the angle and fold it into +/-90 deg with an exact quarter-turn of the lower input
    always_comb begin
        w_zn = -zangle;
        w_x2 = IW'(xin2) <<< G;
        w_y2 = IW'(yin2) <<< G;
        w_px = w_x2;
        w_py = w_y2;
        w_pz = w_zn;
        case (w_zn[31:30])
            2'b01: begin
                w_px = -w_y2;
                w_py = w_x2;
                w_pz = w_zn - 32'sh4000_0000;
            end
            2'b10: begin
                w_px = w_y2;
                w_py = -w_x2;
                w_pz = w_zn + 32'sh4000_0000;
            end
            default: ;
        endcase
    end

    // Stage 0 input register (data path is not reset)
    always_ff @(posedge clk) begin
        r_x[0]  <= w_px;
        r_y[0]  <= w_py;
        r_z[0]  <= w_pz;
        r_ax[0] <= xin1;
        r_ay[0] <= yin1;
    end

    // Valid shift register, cleared by reset so in-flight samples are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= '0;
        end else begin
            r_v <= {r_v[STAGES-1:0], in_valid};
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic signed [31:0] ATAN = atan_lut(i);

        // Micro-rotation i toward zero residual angle; upper input rides alongside
        always_ff @(posedge clk) begin
            r_ax[i+1] <= r_ax[i];
            r_ay[i+1] <= r_ay[i];
            if (r_z[i][31]) begin
                r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
                r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
            end else begin
                r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
                r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
            end
        end

        if (i < STAGES - 1) begin : g_z
            // Residual angle update; the last stage only needs the sign
            always_ff @(posedge clk) begin
                r_z[i+1] <= r_z[i][31] ? r_z[i] + ATAN : r_z[i] - ATAN;
            end
        end
    end

    // Gain compensation; guard bits are kept through the add so only one truncation happens
    always_comb begin
        w_rx = SW'((PW'(r_x[STAGES]) * PW'(GAIN)) >>> 15);
        w_ry = SW'((PW'(r_y[STAGES]) * PW'(GAIN)) >>> 15);
        w_ax = SW'(r_ax[STAGES]) <<< G;
        w_ay = SW'(r_ay[STAGES]) <<< G;
    end

    // Output register: sum/difference, updated only for valid samples
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            xout1     <= 16'sd0;
            yout1     <= 16'sd0;
            xout2     <= 16'sd0;
            yout2     <= 16'sd0;
        end else begin
            out_valid <= r_v[STAGES];
            if (r_v[STAGES]) begin
                xout1 <= 16'((w_ax + w_rx) >>> OSH);
                yout1 <= 16'((w_ay + w_ry) >>> OSH);
                xout2 <= 16'((w_ax - w_rx) >>> OSH);
                yout2 <= 16'((w_ay - w_ry) >>> OSH);
            end
        end
    end

endmodule

// File: tb/tb_ifft_butterfly.sv
// Self-checking bench for ifft_butterfly against a floating-point reference.
module tb_ifft_butterfly;

    localparam int LAT = 18;
`ifdef IFFT_BUTTERFLY_SCALE_EN
    localparam real SCALE = 0.5;
    localparam int  TOL   = 2;
    localparam int  MUL   = 1;
`else
    localparam real SCALE = 1.0;
    localparam int  TOL   = 4;
    localparam int  MUL   = 2;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [15:0] xin1, yin1, xin2, yin2;
    logic signed [31:0] zangle;
    logic               out_valid;
    logic signed [15:0] xout1, yout1, xout2, yout2;

    ifft_butterfly #(.STAGES(16), .IW(20)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .xin1     (xin1),
        .yin1     (yin1),
        .xin2     (xin2),
        .yin2     (yin2),
        .zangle   (zangle),
        .out_valid(out_valid),
        .xout1    (xout1),
        .yout1    (yout1),
        .xout2    (xout2),
        .yout2    (yout2)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    bit h_v  [0:1023];
    int h_x1 [0:1023];
    int h_y1 [0:1023];
    int h_x2 [0:1023];
    int h_y2 [0:1023];

    logic exp_v = 1'b0;
    int   hx1 = 0, hy1 = 0, hx2 = 0, hy2 = 0, htol = 0;

    // Ideal butterfly: r = b * exp(-j*theta), out = (a +/- r) * S
    task automatic model(input int xa, input int ya, input int xb, input int yb,
                         input logic [31:0] z,
                         output int o1x, output int o1y, output int o2x, output int o2y);
        real th, c, s, rx, ry;
        th  = real'(int'(z)) * 6.283185307179586 / 4294967296.0;
        c   = $cos(th);
        s   = $sin(th);
        rx  = real'(xb) * c + real'(yb) * s;
        ry  = real'(yb) * c - real'(xb) * s;
        o1x = int'((real'(xa) + rx) * SCALE);
        o1y = int'((real'(ya) + ry) * SCALE);
        o2x = int'((real'(xa) - rx) * SCALE);
        o2y = int'((real'(ya) - ry) * SCALE);
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Modular 16-bit distance so wrapped outputs compare correctly
    task automatic chk_near(input string tag, input logic signed [15:0] obs,
                            input int expv, input int tol);
        int d;
        d = int'(obs) - expv;
        d = ((d % 65536) + 65536 + 32768) % 65536 - 32768;
        n_total++;
        assert (((d <= tol) && (d >= -tol)) === 1'b1) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d +/-%0d (cycle %0d)",
                   tag, obs, expv, tol, cyc);
        end
    endtask

    function automatic int rv();
        return int'($urandom_range(32000)) - 16000;
    endfunction

    // One clock: drive inputs, advance, then check every output against the model
    task automatic tick(input logic v, input logic r, input int xa, input int ya,
                        input int xb, input int yb, input logic [31:0] z);
        int e, t1x, t1y, t2x, t2y;
        rst      = r;
        in_valid = v;
        xin1     = 16'(xa);
        yin1     = 16'(ya);
        xin2     = 16'(xb);
        yin2     = 16'(yb);
        zangle   = z;
        model(xa, ya, xb, yb, z, t1x, t1y, t2x, t2y);
        h_v[cyc+1]  = v && !r;
        h_x1[cyc+1] = t1x;
        h_y1[cyc+1] = t1y;
        h_x2[cyc+1] = t2x;
        h_y2[cyc+1] = t2y;
        @(posedge clk);
        cyc++;
        if (r) begin
            for (int j = 0; j <= cyc; j++) h_v[j] = 1'b0;
            exp_v = 1'b0;
            hx1 = 0; hy1 = 0; hx2 = 0; hy2 = 0; htol = 0;
        end else begin
            e = cyc - (LAT - 1);
            if (e >= 1 && h_v[e]) begin
                exp_v = 1'b1;
                hx1 = h_x1[e]; hy1 = h_y1[e]; hx2 = h_x2[e]; hy2 = h_y2[e];
                htol = TOL;
            end else begin
                exp_v = 1'b0;
            end
        end
        @(negedge clk);
        chk_bit("out_valid", out_valid, exp_v);
        chk_near("xout1", xout1, hx1, htol);
        chk_near("yout1", yout1, hy1, htol);
        chk_near("xout2", xout2, hx2, htol);
        chk_near("yout2", yout2, hy2, htol);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, rv(), rv(), rv(), rv(), $urandom());
    endtask

    // Single sample, then check the emerging result against fixed expectations
    task automatic directed(input string tag, input int xa, input int ya, input int xb,
                            input int yb, input logic [31:0] z, input int e1x, input int e1y,
                            input int e2x, input int e2y, input int tol);
        tick(1'b1, 1'b0, xa, ya, xb, yb, z);
        idle(LAT - 1);
        chk_bit({tag, "_valid"}, out_valid, 1'b1);
        chk_near({tag, "_x1"}, xout1, e1x, tol);
        chk_near({tag, "_y1"}, yout1, e1y, tol);
        chk_near({tag, "_x2"}, xout2, e2x, tol);
        chk_near({tag, "_y2"}, yout2, e2y, tol);
        idle(2);
    endtask

    initial begin
        int bx, by;
        for (int j = 0; j < 1024; j++) h_v[j] = 1'b0;

        // Reset state
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, rv(), rv(), rv(), rv(), $urandom());
        idle(2);

        // Zero-angle and quarter-turn directed cases
        directed("zero_ang", 1000, 0, 200, 0, 32'h0000_0000,
                 600 * MUL, 0, 400 * MUL, 0, 2);
        directed("quarter", 0, 0, 0, 1000, 32'h4000_0000,
                 500 * MUL, 0, -500 * MUL, 0, 2);

        // Round trip through a forward butterfly at 45 deg
        bx = int'(real'(3500) * $cos(0.7853981633974483) + real'(3000) * $sin(0.7853981633974483));
        by = int'(real'(3500) * $sin(0.7853981633974483) - real'(3000) * $cos(0.7853981633974483));
        directed("roundtrip", 2500, 1000, bx, by, 32'h2000_0000,
                 3000 * MUL, -1000 * MUL, -500 * MUL, 2000 * MUL, 4 * MUL);

        // Large inputs: 17-bit sum either wraps or is halved
`ifdef IFFT_BUTTERFLY_SCALE_EN
        directed("big_sum", 20000, 0, 20000, 0, 32'h0000_0000, 20000, 0, 0, 0, 2);
`else
        directed("big_sum", 20000, 0, 20000, 0, 32'h0000_0000, -25536, 0, 0, 0, 2);
`endif

        // Random burst: 100 back-to-back, 10-cycle gap, 7 more
        for (int k = 0; k < 100; k++) tick(1'b1, 1'b0, rv(), rv(), rv(), rv(), $urandom());
        idle(10);
        for (int k = 0; k < 7; k++) tick(1'b1, 1'b0, rv(), rv(), rv(), rv(), $urandom());
        idle(LAT + 2);

        // Reset on the 5th sample of a 20-sample burst
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, rv(), rv(), rv(), rv(), $urandom());
        tick(1'b1, 1'b1, rv(), rv(), rv(), rv(), $urandom());
        for (int k = 0; k < 15; k++) tick(1'b1, 1'b0, rv(), rv(), rv(), rv(), $urandom());
        idle(LAT + 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
